// File: rtl/hs_dma_sched.sv
// Round-robin scheduler for the single host DMA command port. Two requesters
// share the port; the granted descriptor is held and completion/watchdog reported.
module hs_dma_sched #(
    parameter int unsigned C_TIMEOUT = 1024,
    parameter int unsigned C_TO_W    = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_address,
    input  logic [31:0] req_length,
    input  logic [7:0]  req_pm,
    input  logic [13:0] req_ctrl,
    output logic        dma_req,
    output logic [31:0] dma_address,
    output logic [15:0] dma_length,
    output logic [3:0]  dma_pm,
    output logic        dma_sof,
    output logic        dma_eof,
    output logic        dma_flush,
    output logic        dma_sync,
    output logic        dma_wrt,
    output logic        dma_data,
    output logic        dma_ok,
    input  logic        dma_ack,
    output logic [1:0]  done,
    output logic [1:0]  timeout,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ZLEN
    } state_t;

    localparam logic [C_TO_W-1:0] LP_TO_LAST = C_TO_W'(C_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant_id;
    logic [C_TO_W-1:0]  r_cnt;
    logic [31:0]        r_addr;
    logic [15:0]        r_len;
    logic [3:0]         r_pm;
    logic [6:0]         r_ctrl;
    logic [1:0]         r_done;
    logic [1:0]         r_timeout;

    logic               w_win;
    logic [1:0]         w_win_oh;
    logic [1:0]         w_own_oh;
    logic               w_accept;
    logic               w_to_hit;
    logic [31:0]        w_addr;
    logic [15:0]        w_len;
    logic [3:0]         w_pm;
    logic [6:0]         w_ctrl;
    logic [1:0]         w_done_nxt;
    logic [1:0]         w_timeout_nxt;

    always_comb begin
        // On a tie the requester that did not own the last grant wins.
        w_win    = (req_valid == 2'b11) ? ~r_grant_id : req_valid[1];
        w_win_oh = w_win ? 2'b10 : 2'b01;
        w_own_oh = r_grant_id ? 2'b10 : 2'b01;
        w_accept = (r_state == S_IDLE) && !sys_rst && (req_valid != '0);
        w_to_hit = (C_TIMEOUT != 0) && (r_cnt == LP_TO_LAST);

        w_addr = w_win ? req_address[63:32] : req_address[31:0];
        w_len  = w_win ? req_length[31:16]  : req_length[15:0];
        w_pm   = w_win ? req_pm[7:4]        : req_pm[3:0];
        w_ctrl = w_win ? req_ctrl[13:7]     : req_ctrl[6:0];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_done_nxt    = '0;
        w_timeout_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_len != '0) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_ZLEN;
                        w_done_nxt  = w_win_oh;
                    end
                end
            end
            S_ISSUE: begin
                // Ack takes priority over a watchdog expiry in the same cycle.
                if (dma_ack) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = w_own_oh;
                end else if (w_to_hit) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = w_own_oh;
                end
            end
            S_ZLEN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_grant_id <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_pm       <= '0;
            r_ctrl     <= '0;
            r_done     <= '0;
            r_timeout  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_accept) begin
                r_grant_id <= w_win;
                r_addr     <= w_addr;
                r_len      <= w_len;
                r_pm       <= w_pm;
                r_ctrl     <= w_ctrl;
                r_cnt      <= '0;
            end else if (r_state == S_ISSUE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready   = w_accept ? w_win_oh : '0;
        dma_req     = (r_state == S_ISSUE);
        busy        = (r_state != S_IDLE);
        grant_id    = r_grant_id;
        done        = r_done;
        timeout     = r_timeout;
        dma_address = r_addr;
        dma_length  = r_len;
        dma_pm      = r_pm;
        dma_sof     = r_ctrl[0];
        dma_eof     = r_ctrl[1];
        dma_flush   = r_ctrl[2];
        dma_sync    = r_ctrl[3];
        dma_wrt     = r_ctrl[4];
        dma_data    = r_ctrl[5];
        dma_ok      = r_ctrl[6];
    end

endmodule

// File: tb/tb_hs_dma_sched.sv
// Directed bench for hs_dma_sched: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_hs_dma_sched;

    localparam int TO = 8;

    logic        sys_clk;
    logic        sys_rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_address;
    logic [31:0] req_length;
    logic [7:0]  req_pm;
    logic [13:0] req_ctrl;
    logic        dma_req;
    logic [31:0] dma_address;
    logic [15:0] dma_length;
    logic [3:0]  dma_pm;
    logic        dma_sof, dma_eof, dma_flush, dma_sync, dma_wrt, dma_data, dma_ok;
    logic        dma_ack;
    logic [1:0]  done;
    logic [1:0]  timeout;
    logic        busy;
    logic        grant_id;

    hs_dma_sched #(.C_TIMEOUT(TO), .C_TO_W(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_length(req_length),
        .req_pm(req_pm), .req_ctrl(req_ctrl),
        .dma_req(dma_req), .dma_address(dma_address),
        .dma_length(dma_length), .dma_pm(dma_pm),
        .dma_sof(dma_sof), .dma_eof(dma_eof), .dma_flush(dma_flush),
        .dma_sync(dma_sync), .dma_wrt(dma_wrt), .dma_data(dma_data),
        .dma_ok(dma_ok), .dma_ack(dma_ack),
        .done(done), .timeout(timeout), .busy(busy), .grant_id(grant_id)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one outstanding-transaction record and the pulses it owes.
    bit          m_ok = 0;
    logic        m_active, m_zl, m_gid;
    int          m_age;
    logic [1:0]  m_done, m_to;
    logic [31:0] m_addr;
    logic [15:0] m_len;
    logic [3:0]  m_pm;
    logic [6:0]  m_ctrl;

    function automatic logic [1:0] exp_ready();
        logic w;
        if (sys_rst || m_active || m_zl || req_valid == 2'b00) return 2'b00;
        w = (req_valid == 2'b11) ? !m_gid : req_valid[1];
        return w ? 2'b10 : 2'b01;
    endfunction

    always @(posedge sys_clk) begin : model
        logic [1:0] g;
        g = exp_ready();
        if (sys_rst) begin
            m_ok = 1; m_active = 0; m_zl = 0; m_gid = 0; m_age = 0;
            m_done = 0; m_to = 0; m_addr = 0; m_len = 0; m_pm = 0; m_ctrl = 0;
        end else begin
            m_done = 0;
            m_to   = 0;
            if (m_active) begin
                if (dma_ack) begin
                    m_done   = m_gid ? 2'b10 : 2'b01;
                    m_active = 0;
                end else if (m_age == TO - 1) begin
                    m_to     = m_gid ? 2'b10 : 2'b01;
                    m_active = 0;
                end else begin
                    m_age++;
                end
            end else if (m_zl) begin
                m_zl = 0;
            end else if (g != 2'b00) begin
                m_gid  = g[1];
                m_addr = req_address[32*g[1] +: 32];
                m_len  = req_length[16*g[1] +: 16];
                m_pm   = req_pm[4*g[1] +: 4];
                m_ctrl = req_ctrl[7*g[1] +: 7];
                if (m_len == 0) begin
                    m_done = g;
                    m_zl   = 1;
                end else begin
                    m_active = 1;
                    m_age    = 0;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (m_ok) begin
            chk("m_req_ready", req_ready, exp_ready());
            chk("m_dma_req", dma_req, m_active);
            chk("m_busy", busy, m_active | m_zl);
            chk("m_grant_id", grant_id, m_gid);
            chk("m_done", done, m_done);
            chk("m_timeout", timeout, m_to);
            chk("m_address", dma_address, m_addr);
            chk("m_length", dma_length, m_len);
            chk("m_pm", dma_pm, m_pm);
            chk("m_ctrl", {dma_ok, dma_data, dma_wrt, dma_sync, dma_flush, dma_eof, dma_sof}, m_ctrl);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic set_req(input logic idx, input logic [31:0] a, input logic [15:0] l,
                           input logic [3:0] p, input logic [6:0] c);
        if (idx) begin
            req_address[63:32] = a; req_length[31:16] = l; req_pm[7:4] = p; req_ctrl[13:7] = c;
        end else begin
            req_address[31:0] = a; req_length[15:0] = l; req_pm[3:0] = p; req_ctrl[6:0] = c;
        end
    endtask

    int n_hi, n_done_seen;
    logic [1:0] to_seen;

    initial begin
        sys_rst = 1; req_valid = 2'b01; dma_ack = 0;
        req_address = '0; req_length = {16'h5, 16'h5}; req_pm = '0; req_ctrl = '0;
        repeat (3) tick();
        at_neg();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_dma_req", dma_req, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick(); sys_rst = 0; req_valid = 2'b00;

        // Single request
        tick();
        set_req(0, 32'h1000_0000, 16'h0200, 4'h0, 7'h41);
        req_valid = 2'b01;
        at_neg(); chk("single_ready_t", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        at_neg();
        chk("single_req_t1", dma_req, 1'b1);
        chk("single_addr_t1", dma_address, 32'h1000_0000);
        chk("single_len_t1", dma_length, 16'h0200);
        chk("single_ok_sof", {dma_ok, dma_sof}, 2'b11);
        repeat (3) tick();
        at_neg();
        chk("single_req_t4", dma_req, 1'b1);
        chk("single_addr_t4", dma_address, 32'h1000_0000);
        tick(); dma_ack = 1;
        tick(); dma_ack = 0;
        at_neg();
        chk("single_done_t6", done, 2'b01);
        chk("single_req_t6", dma_req, 1'b0);

        // Arbitration: both requesters held valid
        set_req(0, 32'h0000_00A0, 16'h0010, 4'h1, 7'h21);
        set_req(1, 32'h0000_00B0, 16'h0020, 4'h2, 7'h11);
        tick(); req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("arb_grant", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) chk("arb_done_overlap", done, (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            tick(); dma_ack = 1;
            tick(); dma_ack = 0;
            if (i == 3) req_valid = 2'b00;
        end
        at_neg();
        chk("arb_last_done", done, 2'b01);
        chk("arb_idle_ready", req_ready, 2'b00);

        // Watchdog timeout on requester 1
        set_req(1, 32'hDEAD_0000, 16'h0040, 4'h3, 7'h12);
        tick(); req_valid = 2'b10;
        at_neg(); chk("to_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        n_hi = 0; n_done_seen = 0; to_seen = 2'b00;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (dma_req) n_hi++;
            to_seen |= timeout;
            if (done != 2'b00) n_done_seen++;
            tick();
        end
        chk("to_req_cycles", n_hi, TO);
        chk("to_pulse", to_seen, 2'b10);
        chk("to_no_done", n_done_seen, 0);

        // Ack on the same cycle as the watchdog limit
        set_req(0, 32'h2000_0000, 16'h0100, 4'h1, 7'h61);
        tick(); req_valid = 2'b01;
        at_neg(); chk("bnd_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        repeat (7) tick();
        dma_ack = 1;
        at_neg(); chk("bnd_req_last", dma_req, 1'b1);
        tick(); dma_ack = 0;
        at_neg();
        chk("bnd_done", done, 2'b01);
        chk("bnd_timeout", timeout, 2'b00);
        chk("bnd_req_low", dma_req, 1'b0);

        // Zero-length descriptor
        set_req(0, 32'h3000_0000, 16'h0000, 4'h2, 7'h03);
        tick(); req_valid = 2'b01;
        at_neg(); chk("zl_ready", req_ready, 2'b01); chk("zl_req_t", dma_req, 1'b0);
        tick(); req_valid = 2'b00;
        at_neg(); chk("zl_done", done, 2'b01); chk("zl_req_t1", dma_req, 1'b0); chk("zl_busy", busy, 1'b1);
        tick();
        at_neg(); chk("zl_done_end", done, 2'b00); chk("zl_req_t2", dma_req, 1'b0); chk("zl_idle", busy, 1'b0);

        // Reset while a request is outstanding
        set_req(1, 32'h4000_0000, 16'h0080, 4'h5, 7'h50);
        tick(); req_valid = 2'b10;
        tick(); req_valid = 2'b00;
        at_neg(); chk("mr_req", dma_req, 1'b1); chk("mr_gid", grant_id, 1'b1);
        tick(); sys_rst = 1;
        tick(); sys_rst = 0;
        at_neg();
        chk("mr_req_low", dma_req, 1'b0);
        chk("mr_gid_zero", grant_id, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_addr", dma_address, 32'h0);
        chk("mr_pulses", {done, timeout}, 4'h0);

        // Stray acks in IDLE
        tick(); dma_ack = 1;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk("stray_req", dma_req, 1'b0);
            chk("stray_done", done, 2'b00);
            chk("stray_busy", busy, 1'b0);
            tick();
        end
        dma_ack = 0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
